// File: rtl/dma_csr_master.sv
// CSR bus initiator: takes one command from a valid/ready port, runs it as a single
// wait-request transfer to the DMA CSR slave, returns a one-cycle response.
// Optional stall timeout: define DMA_CSR_MASTER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | ready for a command; latch it on cmd_valid_i
// WR_REQ | write strobe asserted, holding until wait-request low
// RD_REQ | read strobe asserted, holding until wait-request low
// RESP   | one-cycle response pulse, strobes low
module dma_csr_master #(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_wr_i,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [DATA_W-1:0]   cmd_data_i,
    input  logic [DATA_W/8-1:0] cmd_be_i,
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_data_o,
    output logic                rsp_err_o,
    output logic                csr_wr_o,
    output logic                csr_rd_o,
    output logic [ADDR_W-1:0]   csr_addr_o,
    output logic [DATA_W-1:0]   csr_wr_data_o,
    output logic [DATA_W/8-1:0] csr_be_o,
    input  logic                csr_wait_rq_i,
    input  logic [DATA_W-1:0]   csr_rd_data_i
);

    localparam int BE_W = DATA_W / 8;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
        $error("dma_csr_master: TIMEOUT_CYCLES must be within 2..255");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_REQ = 2'd1,
        RD_REQ = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state_q;
    state_t state_nxt;

    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              csr_wr_q;
    logic              csr_rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [BE_W-1:0]   be_q;

    logic accept;
    logic req_active;
    logic complete;
    logic abort;

    assign accept     = (state_q == IDLE) && cmd_valid_i && cmd_ready_q;
    assign req_active = (state_q == WR_REQ) || (state_q == RD_REQ);
    assign complete   = req_active && !csr_wait_rq_i;

`ifdef DMA_CSR_MASTER_TIMEOUT_EN
    localparam logic [7:0] STALL_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] stall_q;
    logic       rsp_err_q;

    // Count starts at 0 in the first strobe cycle, so a stuck slave sees exactly
    // TIMEOUT_CYCLES strobe cycles before the abort.
    assign abort = req_active && csr_wait_rq_i && (stall_q == STALL_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q   <= 8'd0;
            rsp_err_q <= 1'b0;
        end else begin
            if (!req_active) begin
                stall_q <= 8'd0;
            end else if (csr_wait_rq_i) begin
                stall_q <= stall_q + 8'd1;
            end
            if (complete) begin
                rsp_err_q <= 1'b0;
            end else if (abort) begin
                rsp_err_q <= 1'b1;
            end
        end
    end

    assign rsp_err_o = rsp_err_q;
`else
    assign abort     = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_nxt = cmd_wr_i ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ, RD_REQ: begin
                if (complete || abort) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Every output is a flop loaded from the next state, so wait-request never
    // reaches the bus combinationally and strobes fall the cycle after completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            csr_wr_q    <= 1'b0;
            csr_rd_q    <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            be_q        <= '0;
        end else begin
            cmd_ready_q <= (state_nxt == IDLE);
            rsp_valid_q <= (state_nxt == RESP);
            csr_wr_q    <= (state_nxt == WR_REQ);
            csr_rd_q    <= (state_nxt == RD_REQ);
            if (accept) begin
                addr_q    <= cmd_addr_i;
                wr_data_q <= cmd_data_i;
                be_q      <= cmd_be_i;
            end
            if (complete) begin
                rsp_data_q <= (state_q == RD_REQ) ? csr_rd_data_i : '0;
            end else if (abort) begin
                rsp_data_q <= '0;
            end
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_data_o    = rsp_data_q;
    assign csr_wr_o      = csr_wr_q;
    assign csr_rd_o      = csr_rd_q;
    assign csr_addr_o    = addr_q;
    assign csr_wr_data_o = wr_data_q;
    assign csr_be_o      = be_q;

endmodule

// File: tb/tb_dma_csr_master.sv
// Bench for dma_csr_master against a small DMA CSR slave model (3 registers at
// 0x0/0x4/0x8, 0 elsewhere). Timeout case runs when DMA_CSR_MASTER_TIMEOUT_EN is defined.
module tb_dma_csr_master;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int TO     = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cmd_valid_i = 1'b0;
    logic              cmd_ready_o;
    logic              cmd_wr_i = 1'b0;
    logic [ADDR_W-1:0] cmd_addr_i = '0;
    logic [DATA_W-1:0] cmd_data_i = '0;
    logic [BE_W-1:0]   cmd_be_i = '0;
    logic              rsp_valid_o;
    logic [DATA_W-1:0] rsp_data_o;
    logic              rsp_err_o;
    logic              csr_wr_o;
    logic              csr_rd_o;
    logic [ADDR_W-1:0] csr_addr_o;
    logic [DATA_W-1:0] csr_wr_data_o;
    logic [BE_W-1:0]   csr_be_o;
    logic              csr_wait_rq_i;
    logic [DATA_W-1:0] csr_rd_data_i;

    always #5 clk = ~clk;

    dma_csr_master #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_wr_i     (cmd_wr_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_data_i   (cmd_data_i),
        .cmd_be_i     (cmd_be_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_err_o    (rsp_err_o),
        .csr_wr_o     (csr_wr_o),
        .csr_rd_o     (csr_rd_o),
        .csr_addr_o   (csr_addr_o),
        .csr_wr_data_o(csr_wr_data_o),
        .csr_be_o     (csr_be_o),
        .csr_wait_rq_i(csr_wait_rq_i),
        .csr_rd_data_i(csr_rd_data_i)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: wait high for the first N strobe cycles (1 for writes, 2 for reads,
    // or stall_len when forced); read data is only valid in the completing cycle.
    logic [31:0] regs [0:3] = '{32'h0, 32'h0, 32'h0, 32'h0};
    int   stall_len = -1;
    int   scnt = 0;
    int   lat_now;
    logic strobe;

    assign strobe = csr_wr_o | csr_rd_o;
    always_comb lat_now = (stall_len >= 0) ? stall_len : (csr_rd_o ? 2 : 1);
    assign csr_wait_rq_i = strobe && (scnt < lat_now);

    function automatic logic [31:0] slave_read(input logic [3:0] a);
        if (a[1:0] != 2'd0 || a[3:2] == 2'd3) return 32'h0;
        return regs[a[3:2]];
    endfunction

    always_comb csr_rd_data_i = csr_wait_rq_i ? 32'hBAD0_BAD0 : slave_read(csr_addr_o);

    always @(posedge clk) begin
        if (strobe && csr_wait_rq_i) scnt <= scnt + 1;
        else scnt <= 0;
        if (csr_wr_o && !csr_wait_rq_i && csr_addr_o[1:0] == 2'd0 && csr_addr_o[3:2] != 2'd3) begin
            for (int b = 0; b < 4; b++) begin
                if (csr_be_o[b]) regs[csr_addr_o[3:2]][8*b +: 8] <= csr_wr_data_o[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc_cyc;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp_data;
        int          exp_len;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[9];

    int total = 0;
    int bad = 0;
    int rsp_seen = 0;
    int overlap = 0;
    int unstable = 0;
    int ready_viol = 0;
    int wr_bursts = 0;
    int cur_len = 0;
    int last_len = 0;
    int gap = 1000;
    int min_gap = 1000;
    logic [3:0]  last_addr = '0;
    logic        last_wr = 1'b0;
    logic        prev_strobe = 1'b0;
    logic [41:0] prev_bus = '0;
    logic [41:0] cur_bus;
    int snap;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic wr, input logic [3:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic [31:0] ed, input logic ee,
                        input int lat, input logic keep);
        exp_t e;
        int n;
        cmd_valid_i = 1'b1;
        cmd_wr_i    = wr;
        cmd_addr_i  = a;
        cmd_data_i  = d;
        cmd_be_i    = be;
        n = 0;
        while (!cmd_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready_o) begin
            total++;
            bad++;
            $display("FAIL accept_timeout got ready=0 want ready=1 within 100 cycles");
            cmd_valid_i = 1'b0;
            return;
        end
        e.data    = ed;
        e.err     = ee;
        e.lat     = lat;
        e.acc_cyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        if (!keep) cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL rsp_timeout got pending=%0d want pending=0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 32'h0,        2};
        vecs[1] = '{1'b0, 4'h4, 32'h0,        4'hF, 32'hDEADBEEF, 3};
        vecs[2] = '{1'b1, 4'h8, 32'hAAAAAAAA, 4'hF, 32'h0,        2};
        vecs[3] = '{1'b1, 4'h8, 32'h12345678, 4'h3, 32'h0,        2};
        vecs[4] = '{1'b0, 4'h8, 32'h0,        4'hF, 32'hAAAA5678, 3};
        vecs[5] = '{1'b0, 4'hC, 32'h0,        4'hF, 32'h0,        3};
        vecs[6] = '{1'b1, 4'h0, 32'hFFFFFFFF, 4'h0, 32'h0,        2};
        vecs[7] = '{1'b0, 4'h0, 32'h0,        4'hF, 32'h0,        3};
        vecs[8] = '{1'b0, 4'h5, 32'h0,        4'hF, 32'h0,        3};

        fork
            forever begin
                @(negedge clk);
                if (reset_n && rsp_valid_o) begin
                    rsp_seen++;
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_rsp got data=%h err=%b want no response", rsp_data_o, rsp_err_o);
                    end else begin
                        mon_e = sb.pop_front();
                        if (rsp_data_o !== mon_e.data || rsp_err_o !== mon_e.err || (cyc - mon_e.acc_cyc) != mon_e.lat) begin
                            bad++;
                            $display("FAIL rsp got data=%h err=%b lat=%0d want data=%h err=%b lat=%0d",
                                     rsp_data_o, rsp_err_o, cyc - mon_e.acc_cyc, mon_e.data, mon_e.err, mon_e.lat);
                        end
                    end
                end
                cur_bus = {csr_wr_o, csr_rd_o, csr_addr_o, csr_wr_data_o, csr_be_o};
                if (csr_wr_o && csr_rd_o) overlap++;
                if (strobe && cmd_ready_o) ready_viol++;
                if (strobe) begin
                    if (!prev_strobe) begin
                        cur_len   = 1;
                        last_addr = csr_addr_o;
                        last_wr   = csr_wr_o;
                        if (csr_wr_o) begin
                            wr_bursts++;
                            if (gap < min_gap) min_gap = gap;
                        end
                    end else begin
                        cur_len++;
                        if (cur_bus != prev_bus) unstable++;
                    end
                    gap = 0;
                end else begin
                    if (prev_strobe) last_len = cur_len;
                    gap++;
                end
                prev_strobe = strobe;
                prev_bus    = cur_bus;
            end
        join_none

        #12;
        check("reset_outputs", {cmd_ready_o, rsp_valid_o, rsp_err_o, csr_wr_o, csr_rd_o,
                                csr_addr_o, csr_wr_data_o, csr_be_o, rsp_data_o} == '0, 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_reset", cmd_ready_o, 1);

        for (int i = 0; i < 9; i++) begin
            send(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].exp_data, 1'b0,
                 vecs[i].exp_len + 1, 1'b0);
            wait_done();
            check("strobe_len", last_len, vecs[i].exp_len);
            check("strobe_addr", last_addr, vecs[i].addr);
            check("strobe_kind", last_wr, vecs[i].wr);
        end

        // Slave stalls 5 cycles; garbage is presented until the completing cycle.
        stall_len = 5;
        send(1'b0, 4'h4, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 7, 1'b0);
        wait_done();
        stall_len = -1;
        check("stall_strobe_len", last_len, 6);

        // Three queued writes with cmd_valid_i held high.
        snap = wr_bursts;
        send(1'b1, 4'h0, 32'h11111111, 4'hF, 32'h0, 1'b0, 3, 1'b1);
        send(1'b1, 4'h4, 32'h22222222, 4'hF, 32'h0, 1'b0, 3, 1'b1);
        send(1'b1, 4'h8, 32'h33333333, 4'hF, 32'h0, 1'b0, 3, 1'b0);
        wait_done();
        check("b2b_bursts", wr_bursts - snap, 3);
        send(1'b0, 4'h4, 32'h0, 4'hF, 32'h22222222, 1'b0, 4, 1'b0);
        wait_done();

        // Reset in the middle of a stalled read.
        stall_len = 5;
        send(1'b0, 4'h8, 32'h0, 4'hF, 32'h33333333, 1'b0, 7, 1'b0);
        @(negedge clk);
        check("rd_before_reset", csr_rd_o, 1);
        #2 reset_n = 1'b0;
        #1;
        check("strobes_drop_on_reset", {csr_wr_o, csr_rd_o, rsp_valid_o}, 3'b000);
        sb.delete();
        snap = rsp_seen;
        repeat (3) @(negedge clk);
        reset_n   = 1'b1;
        stall_len = -1;
        repeat (8) @(negedge clk);
        check("no_rsp_after_reset", rsp_seen - snap, 0);
        send(1'b0, 4'h8, 32'h0, 4'hF, 32'h33333333, 1'b0, 4, 1'b0);
        wait_done();

`ifdef DMA_CSR_MASTER_TIMEOUT_EN
        stall_len = 1000;
        send(1'b0, 4'h4, 32'h0, 4'hF, 32'h0, 1'b1, TO + 1, 1'b0);
        wait_done();
        stall_len = -1;
        check("timeout_strobe_len", last_len, TO);
        check("timeout_err_held", rsp_err_o, 1);
        send(1'b0, 4'h4, 32'h0, 4'hF, 32'h22222222, 1'b0, 4, 1'b0);
        wait_done();
`endif

        check("no_overlap", overlap, 0);
        check("bus_stable", unstable, 0);
        check("ready_low_in_req", ready_viol, 0);
        check("min_gap_ok", min_gap >= 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_csr_master.md
Name: dma_csr_master

Overview:
- Memory-mapped CSR initiator that drives the DMA CSR slave port (wr/rd strobes, 4-bit address, byte enables, wait-request handshake).
- Accepts one command at a time from a local valid/ready command port (test sequencer, debug bridge or descriptor engine).
- Issues the command as a single transfer on the CSR bus, holds it until wait-request deasserts, then returns a one-cycle response with read data or an error flag.

Parameters:
- ADDR_W, 4, CSR address width.
- DATA_W, 32, CSR data width; byte-enable width is DATA_W/8.
- TIMEOUT_CYCLES, 16, cycles a request may stall before abort (used only with the optional feature); legal range 2..255.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
- cmd_wr_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_W  target CSR byte address.
- cmd_data_i  in  DATA_W  write data.
- cmd_be_i  in  DATA_W/8  write byte enables.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_data_o  out  DATA_W  read data; 0 for writes.
- rsp_err_o  out  1  transfer aborted by timeout.
- csr_wr_o  out  1  write strobe to slave.
- csr_rd_o  out  1  read strobe to slave.
- csr_addr_o  out  ADDR_W  address to slave.
- csr_wr_data_o  out  DATA_W  write data to slave.
- csr_be_o  out  DATA_W/8  byte enables to slave.
- csr_wait_rq_i  in  1  slave stall; transfer completes in the cycle it is low.
- csr_rd_data_i  in  DATA_W  slave read data, valid in the completing cycle.

Behaviour:
- Reset (asynchronous, immediate): all outputs 0, state IDLE. Reset mid-transfer drops the strobes at once and produces no response.
- All bus and response outputs are registered; no combinational path from csr_wait_rq_i to csr_* outputs.
- States:
  - IDLE: cmd_ready_o = 1. On cmd_valid_i, latch wr/addr/data/be. Go to WR_REQ or RD_REQ; the strobe rises the next cycle.
  - WR_REQ: csr_wr_o = 1.
  - RD_REQ: csr_rd_o = 1.
  - RESP: one cycle; rsp_valid_o = 1, strobes low, cmd_ready_o = 0; then IDLE.
- In WR_REQ/RD_REQ, csr_addr_o, csr_wr_data_o and csr_be_o stay stable. Strobe, address, data and byte enables are held until the cycle csr_wait_rq_i is sampled low.
- In that completing cycle, capture csr_rd_data_i (reads only) into rsp_data_o and go to RESP. For writes, rsp_data_o = 0.
- csr_wr_o and csr_rd_o are never high together.
- Strobes drop in the cycle after completion, so the slave returns to its idle state before any new request.
- cmd_ready_o is low outside IDLE, so a new command is accepted no earlier than the cycle after rsp_valid_o.
- Back-to-back throughput against the DMA CSR slave:
  - Write: accept at T0, strobe T1, complete T2, rsp_valid_o T3, next accept T4.
  - Read: completes at T3, rsp_valid_o T4.
- No address checks: unaligned or unmapped addresses are passed through unchanged (the slave returns 0). A write with cmd_be_i = 0 is still issued.
- csr_wait_rq_i low in IDLE or RESP is ignored.
- rsp_err_o is 0 unless the optional feature is enabled.

Optional Feature:
- Macro: DMA_CSR_MASTER_TIMEOUT_EN.
- Defined:
  - An 8-bit stall counter clears on entry to WR_REQ/RD_REQ and increments each cycle csr_wait_rq_i is high.
  - When the count reaches TIMEOUT_CYCLES-1 with wait still high, the strobes drop and the block goes to RESP with rsp_err_o = 1 and rsp_data_o = 0.
  - rsp_err_o and rsp_data_o hold until the next response.
- Undefined: no counter; the block waits indefinitely for csr_wait_rq_i low; rsp_err_o is tied 0.

Test Plan:
- Write addr 0x4, data 0xDEADBEEF, be 0xF against the DMA CSR slave -> csr_wr_o high for exactly 2 cycles; rsp_valid_o 3 cycles after accept, rsp_data_o = 0, rsp_err_o = 0. A following read of 0x4 returns 0xDEADBEEF, rsp_valid_o 4 cycles after accept.
- Write 0x8 with be 0x3, data 0x12345678, after the register is preloaded with 0xAAAAAAAA -> read 0x8 returns 0xAAAA5678.
- Read unmapped addr 0xC -> rsp_data_o = 0, rsp_err_o = 0.
- Model slave holding wait high 5 cycles -> csr_rd_o, csr_addr_o and byte enables stable for 6 cycles; data presented in the completing cycle is returned; cmd_ready_o low throughout.
- cmd_valid_i held high with 3 queued writes -> exactly 3 strobe bursts, each separated by at least one idle cycle, with csr_wr_o/csr_rd_o never overlapping.
- reset_n pulsed low mid-read -> strobes low immediately, no rsp_valid_o. With DMA_CSR_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, wait held high forever -> strobe drops after 16 cycles, rsp_err_o = 1, rsp_data_o = 0.
